// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronize, debounce, decode Gray quarter-steps,
// accumulate them into detents and maintain a wrapping or saturating position count.
module quadrature_decoder #(
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 4,
  parameter int DETENT_DIV = 4,
  parameter int SATURATE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir,
  output logic             err
);
  typedef enum logic {SETTLE, RUN} state_t;

  localparam logic [7:0]        DEB_LAST    = 8'(DEB_CYCLES - 1);
  localparam logic [8:0]        SETTLE_LAST = 9'(DEB_CYCLES + 1);
  localparam logic signed [3:0] ACC_TOP     = 4'(DETENT_DIV - 1);
  localparam logic signed [3:0] ACC_BOT     = -ACC_TOP;
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_t            state;
  logic [8:0]        scnt;
  logic [1:0]        sync1, sync2, deb, prev;
  logic [1:0][7:0]   dcnt;
  logic signed [3:0] acc;
  logic [1:0]        delta;
  logic              q_up, q_dn, illegal, up_c, dn_c;

  // Gray code {A,B} -> position around the cycle 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_comb begin
    delta   = gray_pos(deb) - gray_pos(prev);
    q_up    = (state == RUN) && (delta == 2'd1);
    q_dn    = (state == RUN) && (delta == 2'd3);
    illegal = (state == RUN) && (delta == 2'd2);
    up_c    = q_up && (acc == ACC_TOP);
    dn_c    = q_dn && (acc == ACC_BOT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SETTLE;
      scnt    <= '0;
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      prev    <= '0;
      dcnt    <= '0;
      acc     <= '0;
      count   <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;

      // While settling, track the inputs directly so RUN starts with no phantom edge.
      if (state == SETTLE) begin
        deb  <= sync2;
        prev <= sync2;
        dcnt <= '0;
        if (scnt == SETTLE_LAST) state <= RUN;
        else                     scnt  <= scnt + 9'd1;
      end else begin
        prev <= deb;
        for (int c = 0; c < 2; c++) begin
          if (sync2[c] != deb[c]) begin
            if (dcnt[c] == DEB_LAST) begin
              deb[c]  <= sync2[c];
              dcnt[c] <= '0;
            end else begin
              dcnt[c] <= dcnt[c] + 8'd1;
            end
          end else begin
            dcnt[c] <= '0;
          end
        end
      end

      step_up <= up_c && !clear;
      step_dn <= dn_c && !clear;

      if (clear) begin
        count <= '0;
        acc   <= '0;
      end else if (up_c) begin
        acc <= '0;
        dir <= 1'b1;
        if (!(SATURATE != 0 && count == CNT_MAX)) count <= count + CNT_W'(1);
      end else if (dn_c) begin
        acc <= '0;
        dir <= 1'b0;
        if (!(SATURATE != 0 && count == '0)) count <= count - CNT_W'(1);
      end else if (q_up) begin
        acc <= acc + 4'sd1;
      end else if (q_dn) begin
        acc <= acc - 4'sd1;
      end

      if (illegal)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: three configurations driven in parallel, checked
// every cycle against a history-based behavioural model plus directed literal checks.
module tb_quadrature_decoder;
  logic clk = 1'b0;
  logic rst_n, enc_a, enc_b, clear, err_clr;
  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic [2:0] up, dn, dir, err;

  always #5 clk = ~clk;

  quadrature_decoder u0 (.clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
    .clear(clear), .err_clr(err_clr), .count(cnt0), .step_up(up[0]), .step_dn(dn[0]),
    .dir(dir[0]), .err(err[0]));
  quadrature_decoder #(.SATURATE(1)) u1 (.clk(clk), .rst_n(rst_n), .enc_a(enc_a),
    .enc_b(enc_b), .clear(clear), .err_clr(err_clr), .count(cnt1), .step_up(up[1]),
    .step_dn(dn[1]), .dir(dir[1]), .err(err[1]));
  quadrature_decoder #(.CNT_W(4), .DEB_CYCLES(1), .DETENT_DIV(2), .SATURATE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .err_clr(err_clr), .count(cnt2), .step_up(up[2]), .step_dn(dn[2]), .dir(dir[2]),
    .err(err[2]));

  typedef struct {
    int count, acc, scnt;
    bit err, dir, up, dn;
    bit [1:0] deb, prev;
  } model_t;

  bit [1:0] hist[$];
  model_t m0, m1, m2;
  int tests = 0, fails = 0, nedge = 0;
  int up_n[3], dn_n[3];
  bit rnd = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qpos(input bit [1:0] g);
    case (g)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // One clock edge of the reference: hist holds raw samples, newest last.
  function automatic model_t mstep(model_t m, int deb, int div, int w, bit sat,
                                   bit rst, bit clr, bit eclr);
    bit [1:0] nd;
    int sz, d, q, maxv;
    bit ill;
    m.up = 0; m.dn = 0;
    if (rst) begin
      m.count = 0; m.acc = 0; m.scnt = 0; m.err = 0; m.dir = 0; m.deb = 0; m.prev = 0;
      return m;
    end
    sz = hist.size();
    maxv = (1 << w) - 1;
    // A level flips once the synchronized input has disagreed for deb samples in a row.
    nd = m.deb;
    for (int c = 0; c < 2; c++) begin
      bit all;
      all = 1;
      for (int j = 0; j < deb; j++) if (hist[sz-3-j][c] == m.deb[c]) all = 0;
      if (all) nd[c] = !m.deb[c];
    end
    q = 0; ill = 0;
    if (m.scnt >= deb + 2) begin
      d = (qpos(m.deb) - qpos(m.prev) + 4) % 4;
      if (d == 1) q = 1;
      else if (d == 3) q = -1;
      else if (d == 2) ill = 1;
    end
    if (clr) begin
      m.count = 0; m.acc = 0;
    end else if (q == 1 && m.acc + 1 == div) begin
      m.acc = 0; m.up = 1; m.dir = 1;
      m.count = (m.count == maxv) ? (sat ? maxv : 0) : m.count + 1;
    end else if (q == -1 && m.acc - 1 == -div) begin
      m.acc = 0; m.dn = 1; m.dir = 0;
      m.count = (m.count == 0) ? (sat ? 0 : maxv) : m.count - 1;
    end else begin
      m.acc += q;
    end
    if (ill) m.err = 1;
    else if (eclr) m.err = 0;
    if (m.scnt < deb + 2) begin
      m.deb = hist[sz-3]; m.prev = hist[sz-3]; m.scnt++;
    end else begin
      m.prev = m.deb; m.deb = nd;
    end
    return m;
  endfunction

  initial for (int i = 0; i < 32; i++) hist.push_back(2'b00);

  always @(posedge clk) begin
    hist.push_back(rst_n ? {enc_a, enc_b} : 2'b00);
    void'(hist.pop_front());
    m0 = mstep(m0, 4, 4, 8, 0, !rst_n, clear, err_clr);
    m1 = mstep(m1, 4, 4, 8, 1, !rst_n, clear, err_clr);
    m2 = mstep(m2, 1, 2, 4, 0, !rst_n, clear, err_clr);
    nedge++;
  end

  always @(negedge clk) begin
    if (nedge > 0) begin
      chk("u0.count", 16'(cnt0), 16'(m0.count));
      chk("u0.up", 16'(up[0]), 16'(m0.up));
      chk("u0.dn", 16'(dn[0]), 16'(m0.dn));
      chk("u0.dir", 16'(dir[0]), 16'(m0.dir));
      chk("u0.err", 16'(err[0]), 16'(m0.err));
      chk("u1.count", 16'(cnt1), 16'(m1.count));
      chk("u1.up", 16'(up[1]), 16'(m1.up));
      chk("u1.dn", 16'(dn[1]), 16'(m1.dn));
      chk("u1.dir", 16'(dir[1]), 16'(m1.dir));
      chk("u1.err", 16'(err[1]), 16'(m1.err));
      chk("u2.count", 16'(cnt2), 16'(m2.count));
      chk("u2.up", 16'(up[2]), 16'(m2.up));
      chk("u2.dn", 16'(dn[2]), 16'(m2.dn));
      chk("u2.dir", 16'(dir[2]), 16'(m2.dir));
      chk("u2.err", 16'(err[2]), 16'(m2.err));
      chk("excl", 16'(up & dn), 16'd0);
      for (int i = 0; i < 3; i++) begin
        if (up[i] === 1'b1) up_n[i]++;
        if (dn[i] === 1'b1) dn_n[i]++;
      end
    end
  end

  task automatic setab(input bit [1:0] v, input int n);
    {enc_a, enc_b} = v;
    repeat (n) begin
      @(negedge clk);
      if (rnd) begin
        clear   = ($urandom_range(0, 39) == 0);
        err_clr = ($urandom_range(0, 19) == 0);
      end
    end
  endtask

  function automatic bit [1:0] gray(input int p);
    case (p & 3)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    int u0s, d0s, d1s, pulses, at, cur, r;
    rst_n = 0; clear = 0; err_clr = 0; {enc_a, enc_b} = 2'b11;
    repeat (4) @(negedge clk);
    chk("rst.count", 16'(cnt0), 16'd0);
    chk("rst.dir", 16'(dir[0]), 16'd0);
    rst_n = 1;
    setab(2'b11, 12);
    chk("settle11.err", 16'(err[0]), 16'd0);
    chk("settle11.count", 16'(cnt0), 16'd0);

    // Partial detent, then reset: the pending quarters must be forgotten.
    rst_n = 0; setab(2'b00, 3); rst_n = 1; setab(2'b00, 12);
    setab(2'b01, 10); setab(2'b11, 10);
    rst_n = 0; setab(2'b00, 2); rst_n = 1; setab(2'b00, 12);
    chk("rerst.count", 16'(cnt0), 16'd0);

    // One clockwise detent.
    u0s = up_n[0];
    setab(2'b01, 10); setab(2'b11, 10); setab(2'b10, 10);
    chk("cw3q.count", 16'(cnt0), 16'd0);
    {enc_a, enc_b} = 2'b00;
    pulses = 0; at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (up[0] === 1'b1) begin pulses++; at = i; end
    end
    chk("cw.pulses", 16'(pulses), 16'd1);
    chk("cw.latency", 16'(at), 16'd7);
    chk("cw.count", 16'(cnt0), 16'd1);
    chk("cw.dir", 16'(dir[0]), 16'd1);
    chk("cw.u1count", 16'(cnt1), 16'd1);
    chk("cw.u2count", 16'(cnt2), 16'd2);

    // Short glitch on A is filtered.
    setab(2'b10, 3); setab(2'b00, 12);
    chk("glitch.count", 16'(cnt0), 16'd1);
    chk("glitch.err", 16'(err[0]), 16'd0);

    // Clear, then one counter-clockwise detent from zero.
    clear = 1; @(negedge clk); clear = 0;
    d0s = dn_n[0]; d1s = dn_n[1];
    setab(2'b10, 10); setab(2'b11, 10); setab(2'b01, 10); setab(2'b00, 12);
    chk("ccw.wrap", 16'(cnt0), 16'd255);
    chk("ccw.sat", 16'(cnt1), 16'd0);
    chk("ccw.dn0", 16'(dn_n[0] - d0s), 16'd1);
    chk("ccw.dn1", 16'(dn_n[1] - d1s), 16'd1);
    chk("ccw.dir", 16'(dir[0]), 16'd0);

    // Clear lands exactly on the completing edge.
    clear = 1; @(negedge clk); clear = 0;
    u0s = up_n[0];
    setab(2'b01, 10); setab(2'b11, 10); setab(2'b10, 10);
    {enc_a, enc_b} = 2'b00;
    repeat (6) @(negedge clk);
    clear = 1; @(negedge clk); clear = 0;
    setab(2'b00, 6);
    chk("clrstep.count", 16'(cnt0), 16'd0);
    chk("clrstep.pulse", 16'(up_n[0] - u0s), 16'd0);

    // Reversal mid-detent.
    u0s = up_n[0]; d0s = dn_n[0];
    setab(2'b01, 10); setab(2'b11, 10); setab(2'b01, 10); setab(2'b00, 12);
    chk("rev.count", 16'(cnt0), 16'd0);
    chk("rev.steps", 16'(up_n[0] - u0s + dn_n[0] - d0s), 16'd0);

    // Both channels flip together.
    setab(2'b11, 12);
    chk("ill.err", 16'(err[0]), 16'd1);
    chk("ill.count", 16'(cnt0), 16'd0);
    err_clr = 1; @(negedge clk); err_clr = 0;
    setab(2'b11, 2);
    chk("errclr.err", 16'(err[0]), 16'd0);

    // Random walk with glitches, illegal jumps, clears and occasional reset.
    cur = 2; rnd = 1;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        cur = cur + (($urandom_range(0, 1) == 1) ? 1 : 3);
        setab(gray(cur), $urandom_range(1, 12));
      end else if (r < 78) begin
        cur = cur + 2;
        setab(gray(cur), $urandom_range(4, 12));
      end else if (r < 96) begin
        setab(gray(cur) ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01), $urandom_range(1, 3));
        setab(gray(cur), $urandom_range(6, 12));
      end else begin
        rst_n = 0; setab(gray(cur), 2); rst_n = 1; setab(gray(cur), 14);
      end
    end
    rnd = 0; clear = 0; err_clr = 0;
    setab(gray(cur), 15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
